// File: rtl/alu32_pkg.sv
// Shared opcode encodings, accumulator type and helpers for the 32-bit ALU.
package alu32_pkg;

  typedef logic [63:0] acc_t;

  localparam logic [4:0] OP_ADD     = 5'b00000;
  localparam logic [4:0] OP_ADDU    = 5'b00001;
  localparam logic [4:0] OP_SUB     = 5'b00010;
  localparam logic [4:0] OP_MULT    = 5'b00011;
  localparam logic [4:0] OP_MULTU   = 5'b00100;
  localparam logic [4:0] OP_AND     = 5'b00101;
  localparam logic [4:0] OP_OR      = 5'b00110;
  localparam logic [4:0] OP_NOR     = 5'b00111;
  localparam logic [4:0] OP_XOR     = 5'b01000;
  localparam logic [4:0] OP_SLL     = 5'b01001;
  localparam logic [4:0] OP_SRL     = 5'b01010;
  localparam logic [4:0] OP_SLLV    = 5'b01011;
  localparam logic [4:0] OP_SLT     = 5'b01100;
  localparam logic [4:0] OP_MOVN    = 5'b01101;
  localparam logic [4:0] OP_MOVZ    = 5'b01110;
  localparam logic [4:0] OP_ROTRV   = 5'b01111;
  localparam logic [4:0] OP_SRA     = 5'b10000;
  localparam logic [4:0] OP_SRAV    = 5'b10001;
  localparam logic [4:0] OP_SLTU    = 5'b10010;
  localparam logic [4:0] OP_MUL     = 5'b10011;
  localparam logic [4:0] OP_MADD    = 5'b10100;
  localparam logic [4:0] OP_MSUB    = 5'b10101;
  localparam logic [4:0] OP_SEH_SEB = 5'b10110;

  // Rotate right by doubling the word and taking the low half.
  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] d;
    d = {v, v} >> amt;
    return d[31:0];
  endfunction

  // True for the opcodes that write HI/LO.
  function automatic logic is_acc_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/alu32_hilo.sv
// Multiplier, 64-bit accumulate/subtract and the HI/LO register pair.
module alu32_hilo
  import alu32_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output acc_t        acc_next,
  output logic [31:0] mul_lo
);

  acc_t acc;
  acc_t sprod;
  acc_t uprod;

  // Sign- or zero-extended 64-bit operands give the exact 64-bit product.
  always_comb begin
    sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uprod = {32'b0, a} * {32'b0, b};
  end

  assign mul_lo = sprod[31:0];

  // Next accumulator value for each multiply/accumulate opcode.
  always_comb begin
    acc_next = acc;
    case (op)
      OP_MULT:  acc_next = sprod;
      OP_MULTU: acc_next = uprod;
      OP_MADD:  acc_next = acc + sprod;
      OP_MSUB:  acc_next = acc - sprod;
      default:  acc_next = acc;
    endcase
  end

  // HI/LO update only on accumulator opcodes; reset wins over any of them.
  always_ff @(posedge Clk) begin
    if (Reset)
      acc <= '0;
    else if (is_acc_op(op))
      acc <= acc_next;
  end

  assign hi = acc[63:32];
  assign lo = acc[31:0];

endmodule

// File: rtl/alu32_bit.sv
// 32-bit MIPS-style ALU: combinational result plus registered HI/LO.
module alu32_bit
  import alu32_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  acc_t        acc_next;
  logic [31:0] mul_lo;

  alu32_hilo u_hilo (
    .Clk      (Clk),
    .Reset    (Reset),
    .op       (ALUControl),
    .a        (A),
    .b        (B),
    .hi       (HI),
    .lo       (LO),
    .acc_next (acc_next),
    .mul_lo   (mul_lo)
  );

  // Result select; accumulator ops report the low word of the next HI/LO.
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      OP_ADD, OP_ADDU: ALUResult = A + B;
      OP_SUB:          ALUResult = A - B;
      OP_AND:          ALUResult = A & B;
      OP_OR:           ALUResult = A | B;
      OP_NOR:          ALUResult = ~(A | B);
      OP_XOR:          ALUResult = A ^ B;
      OP_SLL:          ALUResult = B << Shamt;
      OP_SLLV:         ALUResult = B << A[4:0];
      OP_SRL:          ALUResult = A[0] ? rotr32(B, Shamt) : (B >> Shamt);
      OP_ROTRV:        ALUResult = rotr32(B, A[4:0]);
      OP_SRA:          ALUResult = $signed(B) >>> Shamt;
      OP_SRAV:         ALUResult = $signed(B) >>> A[4:0];
      OP_SLT:          ALUResult = {31'b0, $signed(A) < $signed(B)};
      OP_SLTU:         ALUResult = {31'b0, A < B};
      OP_MOVN:         ALUResult = (B != '0) ? A : '0;
      OP_MOVZ:         ALUResult = (B == '0) ? A : '0;
      OP_MUL:          ALUResult = mul_lo;
      OP_MULT, OP_MULTU, OP_MADD, OP_MSUB:
                       ALUResult = acc_next[31:0];
      OP_SEH_SEB:      ALUResult = A[0] ? {{16{B[15]}}, B[15:0]} : {{24{B[7]}}, B[7:0]};
      default:         ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu32_bit.sv
// Directed self-checking bench for alu32_bit.
module tb_alu32_bit;
  import alu32_pkg::*;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int unsigned n_pass;
  int unsigned n_total;

  alu32_bit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .Shamt      (Shamt),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .HI         (HI),
    .LO         (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge Clk);
    ALUControl = op;
    A = a;
    B = b;
    Shamt = sh;
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    ALUControl = OP_ADD;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    Reset = 1'b1;
    ALUControl = OP_ADD;
    A = '0;
    B = '0;
    Shamt = '0;

    vecs.push_back('{"add_neg",    OP_ADD,     32'd10,        32'hFFFFFFF1, 5'd0,  32'hFFFFFFFB, 1'b0});
    vecs.push_back('{"sub_zero",   OP_SUB,     32'd1,         32'd1,        5'd0,  32'h00000000, 1'b1});
    vecs.push_back('{"addu_wrap",  OP_ADDU,    32'hFFFFFFFF,  32'd1,        5'd0,  32'h00000000, 1'b1});
    vecs.push_back('{"and",        OP_AND,     32'hF0F0F0F0,  32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0});
    vecs.push_back('{"or",         OP_OR,      32'h12340000,  32'h00005678, 5'd0,  32'h12345678, 1'b0});
    vecs.push_back('{"nor",        OP_NOR,     32'h00000000,  32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"xor",        OP_XOR,     32'hAAAAAAAA,  32'hFFFFFFFF, 5'd0,  32'h55555555, 1'b0});
    vecs.push_back('{"sll_31",     OP_SLL,     32'd0,         32'd1,        5'd31, 32'h80000000, 1'b0});
    vecs.push_back('{"sll_0",      OP_SLL,     32'd0,         32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0});
    vecs.push_back('{"sllv",       OP_SLLV,    32'h00000024,  32'h0000000F, 5'd0,  32'h000000F0, 1'b0});
    vecs.push_back('{"srl_rot",    OP_SRL,     32'd1,         32'd15,       5'd2,  32'hC0000003, 1'b0});
    vecs.push_back('{"srl_log",    OP_SRL,     32'd0,         32'd15,       5'd2,  32'h00000003, 1'b0});
    vecs.push_back('{"srl_rot0",   OP_SRL,     32'd1,         32'h89ABCDEF, 5'd0,  32'h89ABCDEF, 1'b0});
    vecs.push_back('{"rotrv",      OP_ROTRV,   32'd4,         32'd16,       5'd0,  32'h00000001, 1'b0});
    vecs.push_back('{"rotrv_32",   OP_ROTRV,   32'd32,        32'h12345678, 5'd0,  32'h12345678, 1'b0});
    vecs.push_back('{"sra",        OP_SRA,     32'd0,         32'h80000000, 5'd4,  32'hF8000000, 1'b0});
    vecs.push_back('{"srav",       OP_SRAV,    32'd28,        32'hF0000000, 5'd0,  32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"slt",        OP_SLT,     32'hFFFFFFFF,  32'd1,        5'd0,  32'h00000001, 1'b0});
    vecs.push_back('{"sltu",       OP_SLTU,    32'hFFFFFFFF,  32'd1,        5'd0,  32'h00000000, 1'b1});
    vecs.push_back('{"movz",       OP_MOVZ,    32'd15,        32'd0,        5'd0,  32'h0000000F, 1'b0});
    vecs.push_back('{"movn_b0",    OP_MOVN,    32'd15,        32'd0,        5'd0,  32'h00000000, 1'b1});
    vecs.push_back('{"movn_b2",    OP_MOVN,    32'd15,        32'd2,        5'd0,  32'h0000000F, 1'b0});
    vecs.push_back('{"mul",        OP_MUL,     32'd10,        32'hFFFFFFF1, 5'd0,  32'hFFFFFF6A, 1'b0});
    vecs.push_back('{"mul_ovf",    OP_MUL,     32'h00010000,  32'h00010000, 5'd0,  32'h00000000, 1'b1});
    vecs.push_back('{"seb",        OP_SEH_SEB, 32'd0,         32'h00000080, 5'd0,  32'hFFFFFF80, 1'b0});
    vecs.push_back('{"seh_neg",    OP_SEH_SEB, 32'd1,         32'h0000FFF0, 5'd0,  32'hFFFFFFF0, 1'b0});
    vecs.push_back('{"seh_pos",    OP_SEH_SEB, 32'd1,         32'h00000010, 5'd0,  32'h00000010, 1'b0});
    vecs.push_back('{"undef_17",   5'b10111,   32'd5,         32'd5,        5'd0,  32'h00000000, 1'b1});
    vecs.push_back('{"undef_1f",   5'b11111,   32'd5,         32'd5,        5'd3,  32'h00000000, 1'b1});

    // Reset state
    do_reset();
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);

    // Combinational table; none of these opcodes may touch HI/LO.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt);
      check({vecs[i].name, "_res"}, ALUResult, vecs[i].res);
      check({vecs[i].name, "_zero"}, {31'b0, Zero}, {31'b0, vecs[i].zero});
    end
    @(posedge Clk);
    #1;
    check("hold_hi", HI, 32'h0);
    check("hold_lo", LO, 32'h0);

    // MULT / MULTU
    do_reset();
    drive(OP_MULT, 32'd10, 32'hFFFFFFF1, 5'd0);
    check("mult_res", ALUResult, 32'hFFFFFF6A);
    @(posedge Clk);
    #1;
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFF6A);
    drive(OP_MULTU, 32'd10, 32'hFFFFFFF1, 5'd0);
    @(posedge Clk);
    #1;
    check("multu_hi", HI, 32'h00000009);
    check("multu_lo", LO, 32'hFFFFFF6A);
    // Non-accumulator ops, including undefined codes, hold HI/LO.
    drive(OP_ADD, 32'd3, 32'd4, 5'd0);
    @(posedge Clk);
    drive(5'b11000, 32'd3, 32'd4, 5'd0);
    @(posedge Clk);
    #1;
    check("hold2_hi", HI, 32'h00000009);
    check("hold2_lo", LO, 32'hFFFFFF6A);

    // MADD twice, then MSUB
    do_reset();
    drive(OP_MADD, 32'd64, 32'd4, 5'd0);
    check("madd1_res", ALUResult, 32'h00000100);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("madd_hi", HI, 32'h0);
    check("madd_lo", LO, 32'h00000200);
    drive(OP_MSUB, 32'd1024, 32'd1000, 5'd0);
    check("msub_res", ALUResult, 32'hFFF06200);
    @(posedge Clk);
    #1;
    check("msub_hi", HI, 32'hFFFFFFFF);
    check("msub_lo", LO, 32'hFFF06200);

    // Reset during MADD: result still combinational, registers cleared.
    @(negedge Clk);
    Reset = 1'b1;
    ALUControl = OP_MADD;
    A = 32'd64;
    B = 32'd4;
    #1;
    check("rst_madd_res", ALUResult, 32'hFFF06300);
    @(posedge Clk);
    #1;
    check("rst_madd_hi", HI, 32'h0);
    check("rst_madd_lo", LO, 32'h0);
    Reset = 1'b0;

    // First MADD after reset accumulates onto zero.
    drive(OP_MADD, 32'd3, 32'd5, 5'd0);
    check("madd0_res", ALUResult, 32'h0000000F);
    @(posedge Clk);
    #1;
    check("madd0_hi", HI, 32'h0);
    check("madd0_lo", LO, 32'h0000000F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
